regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: ALU result (A) and load data (M).
- Tracks per-register pending-write status in a 32-entry busy scoreboard.
- Exposes a combinational hazard flag that decode uses to stall when a source register has an outstanding write.
- Sits between the execute/memory stages and the 32x64 register file. Drives that file's RegWrite, WriteRegister and WriteData inputs.

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the ALU (A) and
// load (M) writeback paths, and tracks pending writes in a busy scoreboard for decode.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            a_valid,
   input  logic [AW-1:0]   a_rd,
   input  logic [XLEN-1:0] a_data,
   output logic            a_ready,
   input  logic            m_valid,
   input  logic [AW-1:0]   m_rd,
   input  logic [XLEN-1:0] m_data,
   output logic            m_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            hazard,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [NREG-1:0] busy_vec
);

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_M = 1'b1
   } grant_e;

   grant_e            last_grant_q, last_grant_d;
   logic              rf_we_q, rf_we_d;
   logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0]   busy_q, busy_d;

   // Grant history register; after reset M is "last", so A wins the first conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= GNT_M;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   // Round-robin grant between A and M, and grant-history update on handshake.
   always_comb begin
      a_ready      = 1'b0;
      m_ready      = 1'b0;
      last_grant_d = last_grant_q;
      if (a_valid && m_valid) begin
         if (last_grant_q == GNT_M) begin
            a_ready = 1'b1;
         end else begin
            m_ready = 1'b1;
         end
      end else if (a_valid) begin
         a_ready = 1'b1;
      end else if (m_valid) begin
         m_ready = 1'b1;
      end
      if (a_ready) begin
         last_grant_d = GNT_A;
      end else if (m_ready) begin
         last_grant_d = GNT_M;
      end
   end

   // Write-stage next state: capture the winning request; x0 is accepted but never written.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (a_ready) begin
         rf_we_d    = (a_rd != AW'(0));
         rf_waddr_d = a_rd;
         rf_wdata_d = a_data;
      end else if (m_ready) begin
         rf_we_d    = (m_rd != AW'(0));
         rf_waddr_d = m_rd;
         rf_wdata_d = m_data;
      end
   end

   // Write-stage registers driving the register file port.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Scoreboard next state: clear on commit, then set on issue so a newer producer wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (issue_valid && (issue_rd != AW'(0))) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Decode hazard from current scoreboard state only; a same-cycle commit is not bypassed.
   always_comb begin
      hazard = ((rs1 != AW'(0)) && busy_q[rs1]) || ((rs2 != AW'(0)) && busy_q[rs2]);
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write stage, x0, scoreboard, reset.
module tb_regfile_wb_arbiter;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            a_valid, m_valid, issue_valid;
   logic [AW-1:0]   a_rd, m_rd, issue_rd, rs1, rs2;
   logic [XLEN-1:0] a_data, m_data;
   logic            a_ready, m_ready, hazard, rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [NREG-1:0] busy_vec;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
      .hazard(hazard), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample registered outputs just after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; a_valid = 1'b0; m_valid = 1'b0; issue_valid = 1'b0;
      a_rd = '0; m_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
      a_data = '0; m_data = '0;
      repeat (2) @(posedge clk);

      // Reset then idle
      @(negedge clk); reset = 1'b0; rs1 = 5'd3; rs2 = 5'd7; #1;
      check("rst_busy",   64'(busy_vec), 64'h0);
      check("rst_we",     64'(rf_we),    64'h0);
      check("rst_hazard", 64'(hazard),   64'h0);

      // Single A write
      @(negedge clk); a_valid = 1'b1; a_rd = 5'd5; a_data = 64'hDEAD; #1;
      check("a_only_ready",  64'(a_ready), 64'h1);
      check("a_only_mready", 64'(m_ready), 64'h0);
      tick();
      check("a_only_we",    64'(rf_we),    64'h1);
      check("a_only_waddr", 64'(rf_waddr), 64'h5);
      check("a_only_wdata", rf_wdata,      64'hDEAD);
      @(negedge clk); a_valid = 1'b0;
      tick();
      check("a_only_we_off",   64'(rf_we),    64'h0);
      check("a_only_hold_adr", 64'(rf_waddr), 64'h5);

      // Conflict from reset: grants alternate A,M,A,M
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      a_valid = 1'b1; a_rd = 5'd2; a_data = 64'h1;
      m_valid = 1'b1; m_rd = 5'd3; m_data = 64'h2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("conf_aready_%0d", i), 64'(a_ready), (i % 2 == 0) ? 64'h1 : 64'h0);
         check($sformatf("conf_mready_%0d", i), 64'(m_ready), (i % 2 == 0) ? 64'h0 : 64'h1);
         tick();
         check($sformatf("conf_we_%0d", i),    64'(rf_we),    64'h1);
         check($sformatf("conf_waddr_%0d", i), 64'(rf_waddr), (i % 2 == 0) ? 64'h2 : 64'h3);
         check($sformatf("conf_wdata_%0d", i), rf_wdata,      (i % 2 == 0) ? 64'h1 : 64'h2);
         @(negedge clk);
      end
      a_valid = 1'b0; m_valid = 1'b0;

      // x0 handling
      @(negedge clk); m_valid = 1'b1; m_rd = 5'd0; m_data = 64'h55; #1;
      check("x0_mready", 64'(m_ready), 64'h1);
      tick();
      check("x0_we", 64'(rf_we), 64'h0);
      @(negedge clk); m_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      check("x0_busy", 64'(busy_vec), 64'h0);

      // Scoreboard / hazard on rd=9
      @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd0; #1;
      check("sb_hazard_pre", 64'(hazard), 64'h0);
      tick();
      check("sb_busy9",   64'(busy_vec), 64'h200);
      check("sb_hazard1", 64'(hazard),   64'h1);
      @(negedge clk); issue_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h77; #1;
      check("sb_wb_ready", 64'(a_ready), 64'h1);
      tick();
      check("sb_wb_we",     64'(rf_we),    64'h1);
      check("sb_wb_waddr",  64'(rf_waddr), 64'h9);
      check("sb_hazard_we", 64'(hazard),   64'h1);
      @(negedge clk); a_valid = 1'b0;
      tick();
      check("sb_hazard_clr", 64'(hazard),   64'h0);
      check("sb_busy_clr",   64'(busy_vec), 64'h0);

      // Same-edge set and clear of rd=9: set wins
      @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd9;
      @(negedge clk); issue_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h88;
      tick();
      check("same_edge_we", 64'(rf_we), 64'h1);
      @(negedge clk); a_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      check("same_edge_busy", 64'(busy_vec), 64'h200);

      // Reset mid-operation with pending write to rd=4
      @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd4;
      @(negedge clk); issue_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd4; a_data = 64'h44;
      tick();
      check("mid_busy_pre", 64'(busy_vec), 64'h210);
      check("mid_we_pre",   64'(rf_we),    64'h1);
      @(negedge clk); a_valid = 1'b0; reset = 1'b1;
      tick();
      check("mid_we",   64'(rf_we),    64'h0);
      check("mid_busy", 64'(busy_vec), 64'h0);
      @(negedge clk); reset = 1'b0;
      a_valid = 1'b1; a_rd = 5'd6; a_data = 64'h6;
      m_valid = 1'b1; m_rd = 5'd7; m_data = 64'h7; #1;
      check("mid_aready", 64'(a_ready), 64'h1);
      check("mid_mready", 64'(m_ready), 64'h0);
      @(negedge clk); a_valid = 1'b0; m_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
